// File: rtl/tqv_reg_arbiter_if.sv
// ---------------------------------------------------------------------------
// tqv_reg_arbiter_if
// Register-access link between one requester and the register arbiter.
//   req   : access request, held until the cycle after ack
//   addr  : register address, stable while req is high
//   we    : 1 = write, 0 = read, stable while req is high
//   wdata : write data, stable while req is high
//   ack   : one-cycle completion pulse (arbiter -> requester)
//   rdata : read data, valid with ack and held until the next read completes
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface tqv_reg_arbiter_if #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8
);
   logic              req;
   logic [ADDR_W-1:0] addr;
   logic              we;
   logic [DATA_W-1:0] wdata;
   logic              ack;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req, addr, we, wdata,
      input  ack, rdata
   );

   modport slave (
      input  req, addr, we, wdata,
      output ack, rdata
   );
endinterface

// File: rtl/tqv_reg_arbiter.sv
// ---------------------------------------------------------------------------
// tqv_reg_arbiter
// Round-robin arbiter sharing one byte-wide peripheral register port between
// two requesters (port 0 = SPI bridge, port 1 = second on-chip master).
// Each grant performs exactly one access: IDLE -> ACCESS -> DONE -> IDLE.
// Ports:
//   i_clk          : clock
//   i_rst          : synchronous active-high reset
//   if_req0/1      : requester links (slave modport)
//   o_address      : address to the peripheral, held outside ACCESS
//   o_data_write   : one-cycle write strobe, only in ACCESS of a write
//   o_data_in      : write data to the peripheral, held outside ACCESS
//   i_data_out     : peripheral read data, combinational on o_address
//   o_busy         : high in any state other than IDLE
// ---------------------------------------------------------------------------
module tqv_reg_arbiter #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   tqv_reg_arbiter_if.slave        if_req0,
   tqv_reg_arbiter_if.slave        if_req1,
   output logic [ADDR_W-1:0]       o_address,
   output logic                    o_data_write,
   output logic [DATA_W-1:0]       o_data_in,
   input  logic [DATA_W-1:0]       i_data_out,
   output logic                    o_busy
);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAccess = 2'd1,
      StDone   = 2'd2
   } state_e;

   state_e              r_state;
   state_e              w_state_next;

   logic                r_last;     // port that won the most recent grant
   logic                r_grant;    // port owning the current transaction
   logic [ADDR_W-1:0]   r_addr;
   logic                r_we;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_rdata0;
   logic [DATA_W-1:0]   r_rdata1;

   logic                w_grant_valid;
   logic                w_grant_port;
   logic                w_capture;

   // Arbitration: a lone requester wins outright; a tie goes to the port
   // that did not win last time.
   always_comb begin
      w_grant_valid = if_req0.req | if_req1.req;
      w_grant_port  = 1'b0;
      if (if_req0.req && if_req1.req) begin
         w_grant_port = ~r_last;
      end else if (if_req1.req) begin
         w_grant_port = 1'b1;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_grant_valid) begin
               w_state_next = StAccess;
            end
         end
         StAccess: w_state_next = StDone;
         StDone:   w_state_next = StIdle;
         default:  w_state_next = StIdle;
      endcase
   end

   // Read data is taken at the end of the single ACCESS cycle.
   assign w_capture = (r_state == StAccess) && !r_we;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= StIdle;
         r_last   <= 1'b1;
         r_grant  <= 1'b0;
         r_addr   <= '0;
         r_we     <= 1'b0;
         r_wdata  <= '0;
         r_rdata0 <= '0;
         r_rdata1 <= '0;
      end else begin
         r_state <= w_state_next;
         // Latch on grant only, so address/data_in hold outside ACCESS.
         if (r_state == StIdle && w_grant_valid) begin
            r_last  <= w_grant_port;
            r_grant <= w_grant_port;
            if (w_grant_port) begin
               r_addr  <= if_req1.addr;
               r_we    <= if_req1.we;
               r_wdata <= if_req1.wdata;
            end else begin
               r_addr  <= if_req0.addr;
               r_we    <= if_req0.we;
               r_wdata <= if_req0.wdata;
            end
         end
         if (w_capture && !r_grant) begin
            r_rdata0 <= i_data_out;
         end
         if (w_capture && r_grant) begin
            r_rdata1 <= i_data_out;
         end
      end
   end

   // Outputs.
   assign o_address    = r_addr;
   assign o_data_in    = r_wdata;
   assign o_data_write = (r_state == StAccess) && r_we;
   assign o_busy       = (r_state != StIdle);

   assign if_req0.ack   = (r_state == StDone) && !r_grant;
   assign if_req1.ack   = (r_state == StDone) &&  r_grant;
   assign if_req0.rdata = r_rdata0;
   assign if_req1.rdata = r_rdata1;

endmodule

// File: tb/tb_tqv_reg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tqv_reg_arbiter
// Directed testbench for tqv_reg_arbiter with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are checked at
// that same point, i.e. they show the state of the cycle just entered.
// ---------------------------------------------------------------------------
module tb_tqv_reg_arbiter;

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DATA_W = 8;

   logic              clk;
   logic              rst;
   logic [ADDR_W-1:0] address;
   logic              data_write;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              busy;

   int n_checks;
   int n_fails;

   tqv_reg_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_p0 ();
   tqv_reg_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_p1 ();

   tqv_reg_arbiter #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .if_req0      (u_p0.slave),
      .if_req1      (u_p1.slave),
      .o_address    (address),
      .o_data_write (data_write),
      .o_data_in    (data_in),
      .i_data_out   (data_out),
      .o_busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic idle_reqs();
      u_p0.req = 1'b0; u_p0.we = 1'b0; u_p0.addr = '0; u_p0.wdata = '0;
      u_p1.req = 1'b0; u_p1.we = 1'b0; u_p1.addr = '0; u_p1.wdata = '0;
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      data_out = '0;
      idle_reqs();
      #1;
      do_reset();
      step();

      // Reset / idle state
      check("rst_ack0",    {31'b0, u_p0.ack}, 32'd0);
      check("rst_ack1",    {31'b0, u_p1.ack}, 32'd0);
      check("rst_rdata0",  {24'b0, u_p0.rdata}, 32'h00);
      check("rst_rdata1",  {24'b0, u_p1.rdata}, 32'h00);
      check("rst_address", {28'b0, address}, 32'd0);
      check("rst_data_in", {24'b0, data_in}, 32'h00);
      check("rst_dwrite",  {31'b0, data_write}, 32'd0);
      check("rst_busy",    {31'b0, busy}, 32'd0);

      // Port 0 write addr=3 wdata=0xA5 (cycle n)
      u_p0.req = 1'b1; u_p0.we = 1'b1; u_p0.addr = 4'd3; u_p0.wdata = 8'hA5;
      step(); // n+1 ACCESS
      check("w0_dwrite_n1",  {31'b0, data_write}, 32'd1);
      check("w0_address_n1", {28'b0, address}, 32'd3);
      check("w0_data_in_n1", {24'b0, data_in}, 32'hA5);
      check("w0_busy_n1",    {31'b0, busy}, 32'd1);
      check("w0_ack0_n1",    {31'b0, u_p0.ack}, 32'd0);
      step(); // n+2 DONE
      check("w0_dwrite_n2",  {31'b0, data_write}, 32'd0);
      check("w0_ack0_n2",    {31'b0, u_p0.ack}, 32'd1);
      check("w0_ack1_n2",    {31'b0, u_p1.ack}, 32'd0);
      check("w0_address_n2", {28'b0, address}, 32'd3);
      step(); // n+3 IDLE
      u_p0.req = 1'b0;
      check("w0_ack0_n3",    {31'b0, u_p0.ack}, 32'd0);
      check("w0_busy_n3",    {31'b0, busy}, 32'd0);
      check("w0_rdata0",     {24'b0, u_p0.rdata}, 32'h00);
      step();
      check("w0_idle_busy",  {31'b0, busy}, 32'd0);

      // Port 1 read addr=5, data_out=0x3C
      u_p1.req = 1'b1; u_p1.we = 1'b0; u_p1.addr = 4'd5;
      data_out = 8'h3C;
      step(); // n+1
      check("r1_address_n1", {28'b0, address}, 32'd5);
      check("r1_dwrite_n1",  {31'b0, data_write}, 32'd0);
      step(); // n+2
      check("r1_ack1_n2",    {31'b0, u_p1.ack}, 32'd1);
      check("r1_ack0_n2",    {31'b0, u_p0.ack}, 32'd0);
      check("r1_rdata1_n2",  {24'b0, u_p1.rdata}, 32'h3C);
      check("r1_rdata0_n2",  {24'b0, u_p0.rdata}, 32'h00);
      step(); // n+3
      u_p1.req = 1'b0;
      data_out = 8'h77;
      step();
      step();
      check("r1_rdata1_hold", {24'b0, u_p1.rdata}, 32'h3C);

      // Contention after reset: order 0,1,0,1 with acks 3 cycles apart
      do_reset();
      data_out = 8'h5A;
      u_p0.req = 1'b1; u_p0.we = 1'b1; u_p0.addr = 4'd1; u_p0.wdata = 8'h11;
      u_p1.req = 1'b1; u_p1.we = 1'b0; u_p1.addr = 4'd2;
      for (int i = 1; i <= 12; i++) begin
         step();
         check($sformatf("rr_ack0_c%0d", i), {31'b0, u_p0.ack},
               {31'b0, (i == 2) || (i == 8)});
         check($sformatf("rr_ack1_c%0d", i), {31'b0, u_p1.ack},
               {31'b0, (i == 5) || (i == 11)});
         check($sformatf("rr_dwrite_c%0d", i), {31'b0, data_write},
               {31'b0, (i == 1) || (i == 7)});
         if (i == 4 || i == 10) begin
            check($sformatf("rr_address_c%0d", i), {28'b0, address}, 32'd2);
         end
         if (i == 12) begin
            u_p0.req = 1'b0;
            u_p1.req = 1'b0;
         end
      end
      check("rr_rdata1", {24'b0, u_p1.rdata}, 32'h5A);
      check("rr_rdata0", {24'b0, u_p0.rdata}, 32'h00);
      step();
      check("rr_idle_busy", {31'b0, busy}, 32'd0);

      // Reset during ACCESS of a write
      u_p0.req = 1'b1; u_p0.we = 1'b1; u_p0.addr = 4'd9; u_p0.wdata = 8'h42;
      step(); // ACCESS
      check("mr_dwrite_access", {31'b0, data_write}, 32'd1);
      rst = 1'b1;
      u_p0.req = 1'b0;
      step();
      rst = 1'b0;
      check("mr_dwrite",  {31'b0, data_write}, 32'd0);
      check("mr_ack0",    {31'b0, u_p0.ack}, 32'd0);
      check("mr_busy",    {31'b0, busy}, 32'd0);
      check("mr_address", {28'b0, address}, 32'd0);
      check("mr_rdata0",  {24'b0, u_p0.rdata}, 32'h00);
      check("mr_rdata1",  {24'b0, u_p1.rdata}, 32'h00);
      step();
      check("mr_ack0_after", {31'b0, u_p0.ack}, 32'd0);

      // Port 0 drops req in ACCESS: read still completes
      data_out = 8'h99;
      u_p0.req = 1'b1; u_p0.we = 1'b0; u_p0.addr = 4'd4;
      step(); // ACCESS
      u_p0.req = 1'b0;
      check("dr_address", {28'b0, address}, 32'd4);
      step(); // DONE
      check("dr_ack0",   {31'b0, u_p0.ack}, 32'd1);
      check("dr_rdata0", {24'b0, u_p0.rdata}, 32'h99);
      step();
      check("dr_busy",   {31'b0, busy}, 32'd0);

      // req1 rises while port 0 is in ACCESS
      u_p0.req = 1'b1; u_p0.we = 1'b1; u_p0.addr = 4'd6; u_p0.wdata = 8'h66;
      step(); // n+1 ACCESS port 0
      u_p1.req = 1'b1; u_p1.we = 1'b1; u_p1.addr = 4'd7; u_p1.wdata = 8'h77;
      check("lr_address0", {28'b0, address}, 32'd6);
      step(); // n+2 DONE
      check("lr_ack0", {31'b0, u_p0.ack}, 32'd1);
      check("lr_ack1_early", {31'b0, u_p1.ack}, 32'd0);
      step(); // n+3 IDLE, port 1 granted at end
      u_p0.req = 1'b0;
      check("lr_busy_idle", {31'b0, busy}, 32'd0);
      check("lr_dwrite_idle", {31'b0, data_write}, 32'd0);
      step(); // n+4 ACCESS port 1
      check("lr_dwrite1",  {31'b0, data_write}, 32'd1);
      check("lr_address1", {28'b0, address}, 32'd7);
      check("lr_data_in1", {24'b0, data_in}, 32'h77);
      step(); // n+5 DONE
      check("lr_ack1", {31'b0, u_p1.ack}, 32'd1);
      check("lr_ack0_late", {31'b0, u_p0.ack}, 32'd0);
      u_p1.req = 1'b0;
      step();
      step();
      check("lr_busy_end", {31'b0, busy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/tqv_reg_arbiter.md
# tqv_reg_arbiter

Two-requester arbiter that shares the single byte-wide peripheral register port (4-bit address, 8-bit write data, write strobe, 8-bit read data) between the SPI register bridge and a second on-chip master, such as a polling sequencer or debug host. It sits between the requesters and the peripheral under test in the peripheral harness. It serialises accesses with round-robin fairness, issues exactly one register access per grant, and returns read data with a one-cycle acknowledge.

## Interface
Parameters:
- ADDR_W, 4, register address width
- DATA_W, 8, register data width

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  reset, synchronous, active-high
- req0 / req1  in  1  access request, per requester (0 = SPI bridge, 1 = second master)
- addr0 / addr1  in  ADDR_W  request address; must be stable while req is high
- we0 / we1  in  1  1 = write, 0 = read; must be stable while req is high
- wdata0 / wdata1  in  DATA_W  write data; must be stable while req is high
- ack0 / ack1  out  1  one-cycle pulse marking transaction completion
- rdata0 / rdata1  out  DATA_W  read data; valid with ack, held until that port's next read completes
- address  out  ADDR_W  address to the peripheral
- data_write  out  1  one-cycle write strobe to the peripheral
- data_in  out  DATA_W  write data to the peripheral
- data_out  in  DATA_W  read data from the peripheral, combinational on address
- busy  out  1  high in any state other than IDLE

## Operation
- State machine: IDLE -> ACCESS -> DONE -> IDLE. There are no other states.
- IDLE:
  - If no request is pending, stay in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the port that did not win last; the last-winner pointer resets to 1, so port 0 wins the first tie.
  - On grant: latch the winner's addr, we, wdata and port index; update the pointer; go to ACCESS.
- ACCESS (exactly one cycle):
  - address = latched addr; data_in = latched wdata.
  - data_write = latched we.
  - On reads, capture data_out at the end of the cycle into the granted port's rdata register.
  - Go to DONE.
- DONE (exactly one cycle):
  - Pulse ack for the granted port only.
  - rdata of that port is already valid.
  - Go to IDLE.
- Writes do not update rdata.
- address and data_in hold their last value outside ACCESS.
- data_write is 0 in every state except ACCESS with a write.
- Requester protocol:
  - Deassert req in the cycle after ack, or a new transaction is arbitrated.
  - A requester that holds req continuously gets back-to-back accesses. Under contention these alternate with the other port.
- Dropping req after the grant does not abort the transaction: ACCESS and DONE still complete and ack still pulses.
- A req that rises while busy waits; it is arbitrated on the next IDLE cycle.

## Timing
- Reset values: ack0 = ack1 = 0; rdata0 = rdata1 = 0; address = 0; data_in = 0; data_write = 0; busy = 0; state = IDLE; pointer = 1.
- Reset mid-transaction: next cycle is IDLE with all outputs at reset values. No ack, no data_write, and any captured rdata is cleared.
- Latency, with req sampled high in IDLE at cycle n:
  - data_write and address valid in cycle n+1.
  - ack high in cycle n+2.
  - Earliest next grant in cycle n+3.
- Throughput: one access per 3 cycles. Two contending continuous requesters each get one access per 6 cycles.
- Peripheral read path: data_out must settle within the ACCESS cycle (combinational from address).

## Test plan
- Reset, then idle: all outputs 0 and busy = 0. Assert rst during ACCESS of a write -> data_write deasserts next cycle, no ack, rdata0 = 0.
- Port 0 write addr=3, wdata=0xA5 -> data_write high for exactly 1 cycle at n+1 with address=3, data_in=0xA5; ack0 at n+2; ack1 never asserts.
- Port 1 read addr=5 with data_out=0x3C -> ack1 at n+2 with rdata1=0x3C; rdata0 unchanged; rdata1 still 0x3C after data_out changes.
- Both req rising in the same cycle after reset -> port 0 granted first, port 1 second. With both held for 4 transactions, grant order is 0, 1, 0, 1, with acks 3 cycles apart.
- Port 0 drops req in the ACCESS cycle -> transaction completes and ack0 still pulses at n+2.
- req1 rises while port 0 is in ACCESS -> port 1 granted on the IDLE cycle right after ack0; its data_write occurs 2 cycles after ack0.
